// File: rtl/cla_pipe_alu.sv
// ---------------------------------------------------------------------------
// cla_pipe_alu
//   Two-stage pipelined carry-lookahead adder/ALU with a valid/ready handshake
//   on both sides and an internal accumulator.
//
//   Stage 1 registers bit propagate/generate, group propagate/generate, the
//   carry-in, the mode and the operand sign bits. Stage 2 resolves the group
//   carries by lookahead, expands them to bit carries inside each group, and
//   registers sum/cout/ovf/zero.
//
// Ports
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   ena        global enable; low freezes every register
//   in_valid   operand beat offered
//   in_ready   beat accepted this cycle when in_valid is also high
//   a, b       operands (WIDTH bits)
//   cin        carry-in, used by ADD and ACC
//   mode       00 ADD, 01 SUB, 10 ACC, 11 CLR
//   out_valid  result beat present
//   out_ready  consumer takes the result beat
//   sum        result (WIDTH bits)
//   cout       carry-out (SUB: 1 = no borrow)
//   ovf        two's-complement signed overflow
//   zero       sum == 0
// ---------------------------------------------------------------------------
module cla_pipe_alu #(
    parameter int WIDTH = 8,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG  = WIDTH / GROUP;
    localparam int MSB = WIDTH - 1;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    // ---------------- state ----------------
    logic [WIDTH-1:0] acc_reg;

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_p_reg;
    logic [WIDTH-1:0] s1_g_reg;
    logic [NG-1:0]    s1_gp_reg;
    logic [NG-1:0]    s1_gg_reg;
    logic             s1_cin_reg;
    logic [1:0]       s1_mode_reg;
    logic             s1_xmsb_reg;
    logic             s1_ymsb_reg;

    logic             s2_valid_reg;
    logic [1:0]       s2_mode_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             zero_reg;

    // ---------------- handshake ----------------
    logic s2_adv;
    logic s1_adv;
    logic acc_busy;
    logic acc_hazard;
    logic accept;
    logic drain;

    assign s2_adv   = ena && (!s2_valid_reg || out_ready);
    assign s1_adv   = ena && (!s1_valid_reg || s2_adv);
    // ACC and CLR both have mode[1] set; either one in flight means acc_reg
    // is stale for a following ACC beat.
    assign acc_busy   = (s1_valid_reg && s1_mode_reg[1]) || (s2_valid_reg && s2_mode_reg[1]);
    assign acc_hazard = in_valid && (mode == MODE_ACC) && acc_busy;
    assign in_ready   = s1_adv && !acc_hazard;
    assign accept     = in_valid && in_ready;
    assign drain      = s2_valid_reg && out_ready && ena;

    // ---------------- stage 1: operand select and P/G ----------------
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic             op_c;
    logic [WIDTH-1:0] bit_p;
    logic [WIDTH-1:0] bit_g;
    logic [NG-1:0]    grp_p;
    logic [NG-1:0]    grp_g;

    always_comb begin
        op_x = a;
        op_y = b;
        op_c = cin;
        case (mode)
            MODE_ADD: begin
                op_x = a;
                op_y = b;
                op_c = cin;
            end
            MODE_SUB: begin
                op_y = ~b;
                op_c = 1'b1;
            end
            MODE_ACC: begin
                op_x = acc_reg;
                op_y = a;
            end
            default: begin
                op_x = '0;
                op_y = '0;
                op_c = 1'b0;
            end
        endcase
    end

    assign bit_p = op_x ^ op_y;
    assign bit_g = op_x & op_y;

    // Group generate written as a flat sum of products so no carry chain
    // forms inside a group.
    for (genvar gi = 0; gi < NG; gi++) begin : g_group_pg
        localparam int BASE = gi * GROUP;
        logic g_loc;

        always_comb begin
            logic g_acc;
            logic term;
            g_acc = 1'b0;
            term  = 1'b0;
            for (int k = 0; k < GROUP; k++) begin
                term = bit_g[BASE+k];
                for (int m = k + 1; m < GROUP; m++) begin
                    term = term & bit_p[BASE+m];
                end
                g_acc = g_acc | term;
            end
            g_loc = g_acc;
        end

        assign grp_g[gi] = g_loc;
        assign grp_p[gi] = &bit_p[BASE +: GROUP];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_p_reg     <= '0;
            s1_g_reg     <= '0;
            s1_gp_reg    <= '0;
            s1_gg_reg    <= '0;
            s1_cin_reg   <= 1'b0;
            s1_mode_reg  <= MODE_ADD;
            s1_xmsb_reg  <= 1'b0;
            s1_ymsb_reg  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_p_reg    <= bit_p;
                s1_g_reg    <= bit_g;
                s1_gp_reg   <= grp_p;
                s1_gg_reg   <= grp_g;
                s1_cin_reg  <= op_c;
                s1_mode_reg <= mode;
                s1_xmsb_reg <= op_x[MSB];
                s1_ymsb_reg <= op_y[MSB];
            end
        end
    end

    // ---------------- stage 2: carry lookahead and result ----------------
    // grp_c[j] is the carry into group j; grp_c[NG] is the carry-out.
    // Each one is its own sum of products over the registered group P/G.
    logic [NG:0]      grp_c;
    logic [WIDTH-1:0] bit_c;

    always_comb begin
        logic c_acc;
        logic term;
        c_acc = 1'b0;
        term  = 1'b0;
        for (int j = 0; j <= NG; j++) begin
            c_acc = s1_cin_reg;
            for (int m = 0; m < j; m++) begin
                c_acc = c_acc & s1_gp_reg[m];
            end
            for (int k = 0; k < j; k++) begin
                term = s1_gg_reg[k];
                for (int m = k + 1; m < j; m++) begin
                    term = term & s1_gp_reg[m];
                end
                c_acc = c_acc | term;
            end
            grp_c[j] = c_acc;
        end
    end

    // Bit carries inside a group, seeded by that group's lookahead carry.
    for (genvar gi = 0; gi < NG; gi++) begin : g_bit_carry
        localparam int BASE = gi * GROUP;
        logic [GROUP-1:0] c_loc;

        always_comb begin
            logic c_acc;
            logic term;
            c_acc = 1'b0;
            term  = 1'b0;
            for (int k = 0; k < GROUP; k++) begin
                c_acc = grp_c[gi];
                for (int m = 0; m < k; m++) begin
                    c_acc = c_acc & s1_p_reg[BASE+m];
                end
                for (int n = 0; n < k; n++) begin
                    term = s1_g_reg[BASE+n];
                    for (int m = n + 1; m < k; m++) begin
                        term = term & s1_p_reg[BASE+m];
                    end
                    c_acc = c_acc | term;
                end
                c_loc[k] = c_acc;
            end
        end

        assign bit_c[BASE +: GROUP] = c_loc;
    end

    logic [WIDTH-1:0] sum_next;
    logic             cout_next;
    logic             ovf_next;
    logic             zero_next;

    always_comb begin
        sum_next  = s1_p_reg ^ bit_c;
        cout_next = grp_c[NG];
        ovf_next  = (s1_xmsb_reg == s1_ymsb_reg) && (sum_next[MSB] != s1_xmsb_reg);
        if (s1_mode_reg == MODE_CLR) begin
            sum_next  = '0;
            cout_next = 1'b0;
            ovf_next  = 1'b0;
        end
        zero_next = (sum_next == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_mode_reg  <= MODE_ADD;
            sum_reg      <= '0;
            cout_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            zero_reg     <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            // Results only load with a real beat, so an emptied stage keeps
            // the last values on the outputs.
            if (s1_valid_reg) begin
                s2_mode_reg <= s1_mode_reg;
                sum_reg     <= sum_next;
                cout_reg    <= cout_next;
                ovf_reg     <= ovf_next;
                zero_reg    <= zero_next;
            end
        end
    end

    // Accumulator commits only when the ACC/CLR beat leaves stage 2, so a
    // beat flushed by reset never touches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (drain) begin
            if (s2_mode_reg == MODE_ACC) begin
                acc_reg <= sum_reg;
            end else if (s2_mode_reg == MODE_CLR) begin
                acc_reg <= '0;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_cla_pipe_alu.sv
// ---------------------------------------------------------------------------
// tb_cla_pipe_alu
//   Scoreboard bench for cla_pipe_alu (WIDTH=8, GROUP=4). The stimulus
//   process pushes the expected {sum,cout,ovf,zero} when a beat is accepted;
//   the monitor pops and compares whenever a result beat is taken, and also
//   checks that a stalled output holds steady.
// ---------------------------------------------------------------------------
module tb_cla_pipe_alu;

    localparam logic [1:0] M_ADD = 2'b00;
    localparam logic [1:0] M_SUB = 2'b01;
    localparam logic [1:0] M_ACC = 2'b10;
    localparam logic [1:0] M_CLR = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       cin = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;

    always #5 clk = ~clk;

    cla_pipe_alu #(.WIDTH(8), .GROUP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    int          n_total = 0;
    int          n_pass  = 0;
    logic [10:0] exp_q[$];
    bit          rnd_on  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_total++;
        if (got === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, req);
    endtask

    // Reference for ADD/SUB: plain 9-bit integer addition.
    function automatic logic [10:0] model(input logic [1:0] m, input logic [7:0] x,
                                          input logic [7:0] yb, input logic c);
        logic [7:0] y;
        logic       ci;
        logic [8:0] r;
        logic       v;
        y  = (m == M_SUB) ? ~yb : yb;
        ci = (m == M_SUB) ? 1'b1 : c;
        r  = {1'b0, x} + {1'b0, y} + {8'd0, ci};
        v  = (x[7] == y[7]) && (r[7] != x[7]);
        return {r[7:0], r[8], v, (r[7:0] == 8'h00)};
    endfunction

    // Offer one beat; returns the number of cycles it waited for in_ready.
    // Leaves the caller at posedge+1 after the accepting edge.
    task automatic send(input logic [1:0] m, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, input logic [10:0] e, output int waits);
        bit done;
        mode = m; a = va; b = vb; cin = vc; in_valid = 1'b1;
        waits = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end else begin
                waits++;
                if (waits >= 200) begin
                    check("accept_timeout", 32'(waits), 32'd0);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: one line per result beat taken.
    logic [10:0] prev_out  = 11'd0;
    bit          prev_stall = 1'b0;
    int          beat_n = 0;

    always @(negedge clk) begin
        logic [10:0] cur;
        logic [10:0] e;
        cur = {sum, cout, ovf, zero};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(cur), 32'(prev_out));
            end
            if (out_valid && out_ready && ena) begin
                beat_n++;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_beat: got %h required none", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'(cur), 32'(e));
                    $display("beat %0d: sum=%h cout=%b ovf=%b zero=%b (expected %h)",
                             beat_n, sum, cout, ovf, zero, e);
                end
            end
            prev_stall = out_valid && !(out_ready && ena);
            prev_out   = cur;
        end
    end

    // Random out_ready / ena toggling for the stream phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_on) begin
                out_ready = ($urandom_range(0, 3) != 0);
                ena       = ($urandom_range(0, 4) != 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         w;
        logic [1:0] rm;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", 32'({sum, cout, ovf, zero}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; ena = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // ADD overflow, with latency check
        send(M_ADD, 8'h7F, 8'h01, 1'b0, {8'h80, 1'b0, 1'b1, 1'b0}, w);
        @(negedge clk);
        check("latency_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("latency_cycle2", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        // SUB (cin must be ignored)
        send(M_SUB, 8'h05, 8'h05, 1'b1, {8'h00, 1'b1, 1'b0, 1'b1}, w);
        send(M_SUB, 8'h00, 8'h01, 1'b0, {8'hFF, 1'b0, 1'b0, 1'b0}, w);

        // CLR / ACC chain with hazard stalls
        send(M_CLR, 8'h33, 8'h44, 1'b1, {8'h00, 1'b0, 1'b0, 1'b1}, w);
        send(M_ACC, 8'hF0, 8'hAA, 1'b0, {8'hF0, 1'b0, 1'b0, 1'b0}, w);
        check("acc_hazard_wait1", 32'(w), 32'd2);
        send(M_ACC, 8'h20, 8'h00, 1'b0, {8'h10, 1'b1, 1'b0, 1'b0}, w);
        check("acc_hazard_wait2", 32'(w), 32'd2);
        send(M_ACC, 8'h00, 8'h00, 1'b0, {8'h10, 1'b0, 1'b0, 1'b0}, w);
        send(M_ADD, 8'h01, 8'h01, 1'b1, {8'h03, 1'b0, 1'b0, 1'b0}, w);
        check("add_not_blocked", 32'(w), 32'd0);
        repeat (4) @(posedge clk);
        #1;

        // Back-pressure: fill the pipe, then release
        out_ready = 1'b0;
        send(M_ADD, 8'h01, 8'h02, 1'b0, {8'h03, 1'b0, 1'b0, 1'b0}, w);
        send(M_ADD, 8'h10, 8'h20, 1'b0, {8'h30, 1'b0, 1'b0, 1'b0}, w);
        check("second_accept_wait", 32'(w), 32'd0);
        mode = M_ADD; a = 8'hFF; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("full_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(M_ADD, 8'hFF, 8'h01, 1'b0, {8'h00, 1'b1, 1'b0, 1'b1}, w);
        check("release_wait", 32'(w), 32'd0);
        send(M_ADD, 8'h80, 8'h80, 1'b0, {8'h00, 1'b1, 1'b1, 1'b1}, w);
        repeat (4) @(posedge clk);
        #1;
        check("fill_drain_empty", 32'(exp_q.size()), 32'd0);

        // Random ADD/SUB stream with ena/out_ready toggling
        rnd_on = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rm = ($urandom_range(0, 1) == 1) ? M_SUB : M_ADD;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom_range(0, 1));
            send(rm, ra, rb, rc, model(rm, ra, rb, rc), w);
        end
        rnd_on = 1'b0;
        @(posedge clk); #2;
        ena = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("random_drain", 32'(exp_q.size()), 32'd0);

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(M_ACC, 8'h55, 8'h00, 1'b0, {8'h65, 1'b0, 1'b0, 1'b0}, w);
        send(M_ADD, 8'h11, 8'h22, 1'b0, {8'h33, 1'b0, 1'b0, 1'b0}, w);
        #2;
        rst_n = 1'b0;
        #1;
        check("inflight_rst_valid", 32'(out_valid), 32'd0);
        check("inflight_rst_outputs", 32'({sum, cout, ovf, zero}), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_no_stale", 32'(out_valid), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("post_rst_no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        send(M_ACC, 8'h01, 8'h00, 1'b0, {8'h01, 1'b0, 1'b0, 1'b0}, w);
        check("post_rst_acc_wait", 32'(w), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("final_drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
